// File: rtl/exec_pkg.sv
// Shared encodings for the multi-cycle execute stage: ALU/shift opcodes,
// FSM states and the control bundles carried toward the memory stage.
package exec_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_NOR = 3'b101;
   localparam logic [2:0] ALU_SLT = 3'b110;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b01;
   localparam logic [1:0] SH_SRA = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } exec_state_e;

   // Control captured from decode when a multiply is accepted.
   typedef struct packed {
      logic       readmem;
      logic       writemem;
      logic       selwsource;
      logic       writereg;
      logic       writeov;
      logic [4:0] regdest;
   } id_ctl_t;

   // Control half of the ex_mem pipeline register.
   typedef struct packed {
      logic       valid;
      logic       readmem;
      logic       writemem;
      logic       selwsource;
      logic       writereg;
      logic       ov;
      logic [4:0] regdest;
   } mem_ctl_t;

endpackage

// File: rtl/exec_mc_seq_mul.sv
// Iterative shift-add multiplier on operand magnitudes; the last group of bits
// is folded in combinationally so the final product is ready in the DONE cycle.
module seq_mul
   import exec_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MUL_BPC = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   input  logic                  unsig,
   output logic                  busy,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product,
   output logic                  ov
);
   localparam int MUL_CYCLES = DATA_W / MUL_BPC;
   localparam int CNT_W      = $clog2(MUL_CYCLES + 1);
   localparam int LAST_STEP  = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
   localparam int PW         = DATA_W + MUL_BPC;

   logic [2*DATA_W-1:0] acc_q;
   logic [DATA_W-1:0]   ma_q, mb_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                running_q, neg_q, unsig_q;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [2*DATA_W-1:0] raw;

   // Add mcand*bits into the upper half, then shift the whole accumulator right.
   function automatic logic [2*DATA_W-1:0] shift_add(
      input logic [2*DATA_W-1:0] acc,
      input logic [DATA_W-1:0]   mcand,
      input logic [MUL_BPC-1:0]  bits
   );
      logic [PW-1:0] sum;
      sum = PW'(acc[2*DATA_W-1:DATA_W]) + PW'(mcand) * PW'(bits);
      return (2*DATA_W)'({sum, acc[DATA_W-1:0]} >> MUL_BPC);
   endfunction

   assign a_mag = (~unsig & a[DATA_W-1]) ? -a : a;
   assign b_mag = (~unsig & b[DATA_W-1]) ? -b : b;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_q     <= '0;
         ma_q      <= '0;
         mb_q      <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
         neg_q     <= 1'b0;
         unsig_q   <= 1'b0;
      end else if (start) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         ma_q      <= a_mag;
         mb_q      <= b_mag;
         neg_q     <= ~unsig & (a[DATA_W-1] ^ b[DATA_W-1]);
         unsig_q   <= unsig;
         running_q <= (MUL_CYCLES > 1);
      end else if (running_q) begin
         acc_q <= shift_add(acc_q, ma_q, mb_q[MUL_BPC-1:0]);
         mb_q  <= mb_q >> MUL_BPC;
         cnt_q <= cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(LAST_STEP)) running_q <= 1'b0;
      end
   end

   assign busy    = running_q;
   assign done    = running_q & (cnt_q == CNT_W'(LAST_STEP));
   assign raw     = shift_add(acc_q, ma_q, mb_q[MUL_BPC-1:0]);
   assign product = neg_q ? -raw : raw;
   assign ov      = unsig_q ? (|product[2*DATA_W-1:DATA_W])
                            : (product[2*DATA_W-1:DATA_W] != {DATA_W{product[DATA_W-1]}});

endmodule

// File: rtl/exec_mc.sv
// Execute stage: single-cycle ALU/shifter, iterative multiplier and the
// ex_mem pipeline register with a valid bit.
module exec_mc
   import exec_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5,
   parameter int MUL_BPC = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               id_ex_valid,
   input  logic               id_ex_selalushift,
   input  logic               id_ex_selimregb,
   input  logic [2:0]         id_ex_aluop,
   input  logic               id_ex_unsig,
   input  logic               id_ex_mul,
   input  logic [1:0]         id_ex_shiftop,
   input  logic [SHAMT_W-1:0] id_ex_shiftamt,
   input  logic [DATA_W-1:0]  id_ex_rega,
   input  logic [DATA_W-1:0]  id_ex_regb,
   input  logic [DATA_W-1:0]  id_ex_imedext,
   input  logic               id_ex_readmem,
   input  logic               id_ex_writemem,
   input  logic               id_ex_selwsource,
   input  logic               id_ex_writereg,
   input  logic               id_ex_writeov,
   input  logic [4:0]         id_ex_regdest,
   input  logic               mem_ex_stall,
   output logic               ex_if_stall,
   output logic               ex_mem_valid,
   output logic               ex_mem_readmem,
   output logic               ex_mem_writemem,
   output logic               ex_mem_selwsource,
   output logic               ex_mem_writereg,
   output logic               ex_mem_ov,
   output logic [4:0]         ex_mem_regdest,
   output logic [DATA_W-1:0]  ex_mem_regb,
   output logic [DATA_W-1:0]  ex_mem_wbvalue
);
   localparam int MUL_CYCLES = DATA_W / MUL_BPC;

   exec_state_e       state_q, state_d;
   mem_ctl_t          out_q, out_d;
   logic [DATA_W-1:0] regb_q, regb_d, wb_q, wb_d;
   id_ctl_t           id_ctl, lat_ctl_q;
   logic [DATA_W-1:0] lat_regb_q;

   logic [DATA_W-1:0] opb, sum_w, diff_w, alu_res, sh_res, sc_res;
   logic              alu_ov, slt_w, sc_ov, mul_start;
   logic              mul_busy, mul_done, mul_ov;
   logic [DATA_W-1:0] mul_lo, mul_hi_unused;

   assign opb    = id_ex_selimregb ? id_ex_imedext : id_ex_regb;
   assign sum_w  = id_ex_rega + opb;
   assign diff_w = id_ex_rega - opb;
   assign slt_w  = id_ex_unsig ? (id_ex_rega < opb) : ($signed(id_ex_rega) < $signed(opb));

   always_comb begin
      alu_res = '0;
      alu_ov  = 1'b0;
      case (id_ex_aluop)
         ALU_ADD: begin
            alu_res = sum_w;
            alu_ov  = ~id_ex_unsig & (id_ex_rega[DATA_W-1] == opb[DATA_W-1])
                                   & (sum_w[DATA_W-1] != id_ex_rega[DATA_W-1]);
         end
         ALU_SUB: begin
            alu_res = diff_w;
            alu_ov  = ~id_ex_unsig & (id_ex_rega[DATA_W-1] != opb[DATA_W-1])
                                   & (diff_w[DATA_W-1] != id_ex_rega[DATA_W-1]);
         end
         ALU_AND: alu_res = id_ex_rega & opb;
         ALU_OR:  alu_res = id_ex_rega | opb;
         ALU_XOR: alu_res = id_ex_rega ^ opb;
         ALU_NOR: alu_res = ~(id_ex_rega | opb);
         ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, slt_w};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      sh_res = '0;
      case (id_ex_shiftop)
         SH_SLL:  sh_res = id_ex_regb << id_ex_shiftamt;
         SH_SRL:  sh_res = id_ex_regb >> id_ex_shiftamt;
         SH_SRA:  sh_res = $unsigned($signed(id_ex_regb) >>> id_ex_shiftamt);
         SH_ROR:  sh_res = (id_ex_regb >> id_ex_shiftamt)
                         | (id_ex_regb << (DATA_W - int'(id_ex_shiftamt)));
         default: sh_res = '0;
      endcase
   end

   assign sc_res = id_ex_selalushift ? sh_res : alu_res;
   assign sc_ov  = ~id_ex_selalushift & alu_ov;

   assign id_ctl = {id_ex_readmem, id_ex_writemem, id_ex_selwsource,
                    id_ex_writereg, id_ex_writeov, id_ex_regdest};

   // A multiply is only accepted on an unstalled edge; a stalled request must be re-presented.
   assign mul_start = (state_q == ST_IDLE) & id_ex_valid & id_ex_mul & ~mem_ex_stall;

   seq_mul #(.DATA_W(DATA_W), .MUL_BPC(MUL_BPC)) u_mul (
      .clock   (clock),
      .reset   (reset),
      .start   (mul_start),
      .a       (id_ex_rega),
      .b       (opb),
      .unsig   (id_ex_unsig),
      .busy    (mul_busy),
      .done    (mul_done),
      .product ({mul_hi_unused, mul_lo}),
      .ov      (mul_ov)
   );

   // Upstream holds id_ex_* in any cycle where ex_if_stall is high; it is consumed otherwise.
   assign ex_if_stall = mem_ex_stall | (state_q != ST_IDLE) | mul_busy
                      | ((state_q == ST_IDLE) & id_ex_valid & id_ex_mul);

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      regb_d  = regb_q;
      wb_d    = wb_q;
      case (state_q)
         ST_IDLE: begin
            if (!mem_ex_stall) begin
               if (id_ex_valid && !id_ex_mul) begin
                  out_d.valid      = 1'b1;
                  out_d.readmem    = id_ex_readmem;
                  out_d.writemem   = id_ex_writemem;
                  out_d.selwsource = id_ex_selwsource;
                  out_d.writereg   = id_ex_writereg & (~sc_ov | id_ex_writeov);
                  out_d.ov         = sc_ov;
                  out_d.regdest    = id_ex_regdest;
                  regb_d           = id_ex_regb;
                  wb_d             = sc_res;
               end else begin
                  out_d  = '0;
                  regb_d = '0;
                  wb_d   = '0;
                  if (id_ex_valid) state_d = (MUL_CYCLES > 1) ? ST_MUL : ST_DONE;
               end
            end
         end
         ST_MUL: begin
            out_d  = '0;
            regb_d = '0;
            wb_d   = '0;
            if (mul_done) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (!mem_ex_stall) begin
               out_d.valid      = 1'b1;
               out_d.readmem    = lat_ctl_q.readmem;
               out_d.writemem   = lat_ctl_q.writemem;
               out_d.selwsource = lat_ctl_q.selwsource;
               out_d.writereg   = lat_ctl_q.writereg & (~mul_ov | lat_ctl_q.writeov);
               out_d.ov         = mul_ov;
               out_d.regdest    = lat_ctl_q.regdest;
               regb_d           = lat_regb_q;
               wb_d             = mul_lo;
               state_d          = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         out_q      <= '0;
         regb_q     <= '0;
         wb_q       <= '0;
         lat_ctl_q  <= '0;
         lat_regb_q <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         regb_q  <= regb_d;
         wb_q    <= wb_d;
         if (mul_start) begin
            lat_ctl_q  <= id_ctl;
            lat_regb_q <= id_ex_regb;
         end
      end
   end

   assign ex_mem_valid      = out_q.valid;
   assign ex_mem_readmem    = out_q.readmem;
   assign ex_mem_writemem   = out_q.writemem;
   assign ex_mem_selwsource = out_q.selwsource;
   assign ex_mem_writereg   = out_q.writereg;
   assign ex_mem_ov         = out_q.ov;
   assign ex_mem_regdest    = out_q.regdest;
   assign ex_mem_regb       = regb_q;
   assign ex_mem_wbvalue    = wb_q;

endmodule

// File: doc/exec_mc.md
Name: exec_mc

Overview:
- Parametrised, multi-cycle execute stage for the pipelined core. It sits between decode (id_ex_*) and memory (ex_mem_*).
- Adds the following to single-cycle ALU/shift execution:
  - configurable datapath width;
  - an iterative multiplier with a stall handshake toward fetch/decode;
  - back-pressure from the memory stage;
  - a valid bit on the output pipeline register.
- ALU/shift results still complete in one cycle. Multiplies take MUL_CYCLES + 1 edges.

Parameters:
- DATA_W, 32, datapath width; must be a power of two, ≥ 8.
- SHAMT_W, 5, shift-amount width; equals log2(DATA_W).
- MUL_BPC, 1, multiplier bits retired per cycle; must divide DATA_W; MUL_CYCLES = DATA_W / MUL_BPC.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- id_ex_valid  in  1  decode presents an instruction
- id_ex_selalushift  in  1  1 = shifter result, 0 = ALU/mul result
- id_ex_selimregb  in  1  1 = ALU operand b is id_ex_imedext, 0 = id_ex_regb
- id_ex_aluop  in  3  ALU operation
- id_ex_unsig  in  1  unsigned arithmetic/compare/multiply
- id_ex_mul  in  1  multiply instruction (overrides aluop)
- id_ex_shiftop  in  2  shift operation
- id_ex_shiftamt  in  SHAMT_W  shift amount
- id_ex_rega, id_ex_regb, id_ex_imedext  in  DATA_W  operands
- id_ex_readmem, id_ex_writemem, id_ex_selwsource, id_ex_writereg, id_ex_writeov  in  1  control passed along
- id_ex_regdest  in  5  destination register
- mem_ex_stall  in  1  memory stage cannot accept
- ex_if_stall  out  1  upstream must hold id_ex_* (combinational)
- ex_mem_valid  out  1  output register holds an instruction
- ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg, ex_mem_ov  out  1
- ex_mem_regdest  out  5
- ex_mem_regb, ex_mem_wbvalue  out  DATA_W

Behaviour:
- Reset (asynchronous, any state, including mid-multiply):
  - all ex_mem_* outputs go to 0 and state goes to IDLE;
  - the multiplier accumulator and counter are cleared;
  - the partial product is discarded.
- Operand b is selected combinationally: id_ex_selimregb ? imedext : regb.
- aluop encoding:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor;
  - 110 slt: result is {0…, a<b}, signed unless unsig;
  - 111 reserved, result is 0.
- Overflow (aluov) exists only for add/sub with unsig = 0 (two's-complement overflow). All other ops give aluov = 0.
- shiftop: 00 sll, 01 srl, 10 sra, 11 ror. The operand is id_ex_regb and the amount is shiftamt modulo DATA_W.
- ex_if_stall = mem_ex_stall | (state != IDLE) | (state == IDLE & id_ex_valid & id_ex_mul).
- Writeback gating: ex_mem_writereg = id_ex_writereg & (~ov | id_ex_writeov). ex_mem_ov = ov.
- State IDLE:
  - If mem_ex_stall: hold all ex_mem_* registers.
  - Else if id_ex_valid & ~id_ex_mul: on the next edge, register all control and the result; ex_mem_valid = 1. Latency is 1 edge.
  - Else if id_ex_valid & id_ex_mul:
    - latch |a|, |b| and the result sign (signed mode) plus control;
    - clear the accumulator and counter;
    - go to MUL;
    - load a bubble (ex_mem_valid = 0, readmem = writemem = writereg = 0).
  - Else (no valid instruction): load a bubble.
- State MUL:
  - Each edge retires MUL_BPC multiplier bits into a 2·DATA_W accumulator (shift-add) and increments the counter.
  - Bubbles continue.
  - When the counter reaches MUL_CYCLES − 1 on an edge, go to DONE.
  - mem_ex_stall does not pause iteration.
- State DONE:
  - Apply the sign to the product (negate the 2·DATA_W value if signed and the signs differ).
  - wbvalue = low DATA_W bits.
  - ov = 1 if the high half ≠ 0 (unsigned), or if the high half ≠ sign-extension of bit DATA_W−1 (signed).
  - If ~mem_ex_stall: register the result with the latched control, set ex_mem_valid = 1 and go to IDLE. Otherwise stay in DONE.
- Total multiply latency from acceptance: MUL_CYCLES + 1 edges, plus any mem_ex_stall cycles.
- ex_mem_regb carries the latched regb for a multiply and id_ex_regb for any other instruction.
- Simultaneous multiply request while mem_ex_stall: the request is not accepted. The stall wins and the request must be re-presented.

Decomposition:
- Shared package exec_pkg holds:
  - ALU opcode constants (ALU_ADD … ALU_SLT);
  - shift opcode constants (SH_SLL, SH_SRL, SH_SRA, SH_ROR);
  - state encoding (ST_IDLE, ST_MUL, ST_DONE).
- One sub-module, seq_mul:
  - parametrised by DATA_W and MUL_BPC;
  - ports start, a, b, unsig, busy, done, product[2·DATA_W−1:0], ov;
  - holds the counter and accumulator.
- ALU and shifter are combinational blocks inside exec_mc.

Test Plan:
- Reset low mid-multiply (cycle 5 of MUL), then release → all outputs 0, ex_if_stall = 0 after reset, and the next add executes normally.
- add a = 0x7FFFFFFF, b = 1, unsig = 0, writereg = 1, writeov = 0 → wbvalue 0x80000000, ov = 1, writereg = 0. The same op with writeov = 1 → writereg = 1.
- sra regb = 0x80000010, shiftamt 4, selalushift = 1 → wbvalue 0xF8000001 after 1 edge. ror with amount 8 → 0x10800000.
- Signed mul a = −3, b = 7, MUL_BPC = 1 → ex_if_stall high for 33 edges, bubbles meanwhile, then wbvalue 0xFFFFFFEB, ov = 0, ex_mem_valid = 1.
- Unsigned mul 0x00010000 × 0x00010000 → wbvalue 0, ov = 1. Assert mem_ex_stall during DONE for 3 cycles → result is held, stall persists, and it is released on the first unstalled edge.
- slti with imedext 0xFFFFFFFF vs rega 0: signed → 0, unsigned → 1. A back-to-back add under mem_ex_stall holds ex_mem_* unchanged.
